// File: rtl/pc_unit.sv
// Program counter for the fetch stage: sequential fetch, stall hold, flush redirect
// and a one-entry pending-branch buffer. Define PC_ALIGN_CHECK_EN to trap misaligned targets.
module pc_unit #(
  parameter int unsigned        ADDR_W       = 32,
  parameter int unsigned        STALL_W      = 6,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0]  EXC_VECTOR   = ADDR_W'(32'h0000_0040)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_target,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic               ce,
  output logic               branch_pending,
  output logic               misalign
);

  localparam int unsigned PC_STEP = 4;

  logic              ce_q, ce_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              misalign_q, misalign_d;
  logic              load_c;
  logic [ADDR_W-1:0] load_tgt_c;
  logic [ADDR_W-1:0] pc_plus4_c;

  // Only stall[0] matters here; the remaining bits belong to later stages.
  logic unused_stall;
  assign unused_stall = ^stall;

  assign pc_plus4_c = pc_q + ADDR_W'(PC_STEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_q       <= 1'b0;
      pc_q       <= RESET_VECTOR;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      ce_q       <= ce_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      misalign_q <= misalign_d;
    end
  end

  // Priority: flush, stalled branch capture, stall hold, live branch, pending branch, pc+4.
  always_comb begin
    ce_d       = 1'b1;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    misalign_d = 1'b0;
    load_c     = 1'b0;
    load_tgt_c = '0;
    if (!ce_q) begin
      pc_d       = RESET_VECTOR;
      pend_d     = 1'b0;
      pend_tgt_d = '0;
    end else if (flush) begin
      load_c     = 1'b1;
      load_tgt_c = flush_target;
      pend_d     = 1'b0;
      pend_tgt_d = '0;
    end else if (stall[0]) begin
      if (branch_flag) begin
        pend_d     = 1'b1;
        pend_tgt_d = branch_target;
      end
    end else if (branch_flag) begin
      load_c     = 1'b1;
      load_tgt_c = branch_target;
      pend_d     = 1'b0;
      pend_tgt_d = '0;
    end else if (pend_q) begin
      load_c     = 1'b1;
      load_tgt_c = pend_tgt_q;
      pend_d     = 1'b0;
      pend_tgt_d = '0;
    end else begin
      pc_d = pc_plus4_c;
    end

    if (load_c) begin
`ifdef PC_ALIGN_CHECK_EN
      if (load_tgt_c[1:0] != 2'b00) begin
        pc_d       = EXC_VECTOR;
        misalign_d = 1'b1;
      end else begin
        pc_d = load_tgt_c;
      end
`else
      pc_d = load_tgt_c;
`endif
    end
  end

`ifndef PC_ALIGN_CHECK_EN
  logic unused_exc;
  assign unused_exc = ^EXC_VECTOR;
`endif

  assign pc             = pc_q;
  assign pc_plus4       = pc_plus4_c;
  assign ce             = ce_q;
  assign branch_pending = pend_q;
  assign misalign       = misalign_q;

endmodule
